// File: rtl/writeback_stage.sv
// writeback_stage: Euler writeback pass x[row] += (h * sum(products)) >>> FRAC_BITS per row.
// Ports: clk, rst (async, active-high); start + base_addr/row_count/step_h begin a pass;
// prod_valid/prod_last/prod_data/prod_ready stream product terms; mem_addr/mem_rd_en/mem_rdata/
// mem_wr_en/mem_wdata access the state vector; row_done and final_done pulse on progress.
// Macro WRITEBACK_SAT_EN selects saturating arithmetic; otherwise results wrap.
module writeback_stage #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic [ADD_SIZE-1:0]  row_count,
  input  logic [DATA_SIZE-1:0] step_h,
  input  logic                 prod_valid,
  input  logic                 prod_last,
  input  logic [DATA_SIZE-1:0] prod_data,
  output logic                 prod_ready,
  output logic [ADD_SIZE-1:0]  mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 mem_wr_en,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 row_done,
  output logic                 final_done
);
  localparam int W = 2 * DATA_SIZE + 1;
  typedef enum logic [2:0] {IDLE, ACC, RD, CALC, WR, DONE} state_t;
  state_t state, nxt;
  logic [ADD_SIZE-1:0] base, rows, row;
  logic signed [DATA_SIZE-1:0] h, acc, x_new, acc_sum, x_calc;
  logic signed [W-1:0] prod;
  logic take;
  function automatic logic signed [W-1:0] ext(input logic signed [DATA_SIZE-1:0] v);
    return {{(DATA_SIZE + 1){v[DATA_SIZE-1]}}, v};
  endfunction
  // Reduce a wide signed intermediate to DATA_SIZE bits.
  function automatic logic signed [DATA_SIZE-1:0] fit(input logic signed [W-1:0] v);
`ifdef WRITEBACK_SAT_EN
    logic signed [W-1:0] maxv, minv;
    maxv = {{(DATA_SIZE + 2){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    minv = {{(DATA_SIZE + 2){1'b1}}, {(DATA_SIZE - 1){1'b0}}};
    return v > maxv ? maxv[DATA_SIZE-1:0] : v < minv ? minv[DATA_SIZE-1:0] : v[DATA_SIZE-1:0];
`else
    return v[DATA_SIZE-1:0];
`endif
  endfunction
  assign take       = prod_valid && prod_ready;
  assign prod       = ext(h) * ext(acc);
  assign acc_sum    = fit(ext(acc) + ext(prod_data));
  assign x_calc     = fit(ext(mem_rdata) + ext(fit(prod >>> FRAC_BITS)));
  // Outputs decode the state alone, so an async reset zeroes them at once.
  assign prod_ready = state == ACC;
  assign mem_rd_en  = state == RD;
  assign mem_wr_en  = state == WR;
  assign row_done   = state == WR;
  assign final_done = state == DONE;
  assign mem_addr   = (state == RD || state == WR) ? base + row : '0;
  assign mem_wdata  = state == WR ? x_new : '0;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? (row_count == '0 ? DONE : ACC) : IDLE;
      ACC:     nxt = (take && prod_last) ? RD : ACC;
      RD:      nxt = CALC;
      CALC:    nxt = WR;
      WR:      nxt = row == rows - ADD_SIZE'(1) ? DONE : ACC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      rows  <= '0;
      row   <= '0;
      h     <= '0;
      acc   <= '0;
      x_new <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (start) begin
          base <= base_addr;
          rows <= row_count;
          h    <= step_h;
          acc  <= '0;
          row  <= '0;
        end
        ACC:  if (take) acc <= acc_sum;
        CALC: x_new <= x_calc;
        WR: begin
          acc <= '0;
          row <= row + ADD_SIZE'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and random passes checked against an arithmetic model.
module tb_writeback_stage;
  localparam int FB = 8;
  logic clk = 0, rst = 1, start = 0, prod_valid = 0, prod_last = 0;
  logic [15:0] base_addr = 0, row_count = 0, step_h = 0, prod_data = 0, mem_rdata;
  logic prod_ready, mem_rd_en, mem_wr_en, row_done, final_done;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem [0:65535];
  logic [15:0] cur_base, cur_rows, cur_h;
  logic [15:0] pq[$];
  int cur_row, passed = 0, failed = 0, total = 0, rd_cnt = 0, wr_cnt = 0, rd0, wr0;

  writeback_stage #(.ADD_SIZE(16), .DATA_SIZE(16), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .step_h(step_h), .prod_valid(prod_valid), .prod_last(prod_last), .prod_data(prod_data),
    .prod_ready(prod_ready), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .row_done(row_done), .final_done(final_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] fit(input longint v);
`ifdef WRITEBACK_SAT_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_pass(input logic [15:0] b, input logic [15:0] r, input logic [15:0] h);
    base_addr = b; row_count = r; step_h = h; start = 1;
    tick;
    start = 0;
    cur_base = b; cur_rows = r; cur_h = h; cur_row = 0;
    if (r == 0) begin
      chk("zero_rows_done", 64'({final_done, mem_rd_en, mem_wr_en, prod_ready}), 64'(4'b1000));
      tick;
      chk("zero_rows_idle", 64'({final_done, prod_ready}), 64'(0));
    end else chk("enter_acc", 64'({prod_ready, mem_addr}), 64'({1'b1, 16'h0}));
  endtask

  // hold: keep prod_valid high after the last product and pulse start mid-row.
  // abort: assert rst during CALC instead of finishing the row.
  task automatic run_row(input bit hold, input bit abort);
    logic [15:0] acc, exp_x, addr;
    int n;
    acc = 0;
    addr = cur_base + cur_row[15:0];
    foreach (pq[i]) begin
      prod_valid = 1; prod_data = pq[i]; prod_last = (i == pq.size() - 1);
      n = 0;
      while (!prod_ready && n < 50) begin tick; n++; end
      chk("ready_wait", 64'(n < 50), 64'(1));
      acc = fit(sx(acc) + sx(pq[i]));
      tick;
    end
    exp_x = fit(sx(mem[addr]) + sx(fit((sx(cur_h) * sx(acc)) >>> FB)));
    if (hold) prod_data = 16'h1234;
    else begin prod_valid = 0; prod_last = 0; end
    chk("rd_cycle", 64'({mem_rd_en, mem_wr_en, prod_ready, row_done, mem_addr}), 64'({4'b1000, addr}));
    tick;
    chk("calc_cycle", 64'({mem_rd_en, mem_wr_en, prod_ready, row_done, final_done}), 64'(0));
    if (abort) begin
      rst = 1;
      #1;
      chk("async_rst_outs", 64'({prod_ready, mem_rd_en, mem_wr_en, row_done, final_done, mem_addr, mem_wdata}), 64'(0));
      tick;
      rst = 0;
      prod_valid = 0; prod_last = 0;
      return;
    end
    if (hold) begin start = 1; base_addr = 16'hbeef; row_count = 16'd7; end
    tick;
    start = 0;
    chk("wr_cycle", 64'({mem_wr_en, mem_rd_en, row_done, prod_ready, final_done, mem_addr, mem_wdata}),
        64'({5'b10100, addr, exp_x}));
    tick;
    prod_valid = 0; prod_last = 0;
    cur_row++;
    if (cur_row == int'(cur_rows)) begin
      chk("final_done", 64'({final_done, prod_ready, mem_wr_en, mem_rd_en, mem_addr}), 64'({4'b1000, 16'h0}));
      tick;
      chk("back_idle", 64'({final_done, prod_ready}), 64'(0));
    end else chk("next_acc", 64'({prod_ready, final_done, mem_addr}), 64'({2'b10, 16'h0}));
  endtask

  initial begin
    repeat (2) tick;
    chk("reset_outs", 64'({prod_ready, mem_rd_en, mem_wr_en, row_done, final_done, mem_addr, mem_wdata}), 64'(0));
    rst = 0;
    tick;
    // two-row worked example
    mem[16'h0100] = 16'h0200; mem[16'h0101] = 16'h0100;
    start_pass(16'h0100, 16'd2, 16'h0080);
    pq = '{16'h0100, 16'h0100};
    run_row(0, 0);
    chk("row0_mem", 64'(mem[16'h0100]), 64'(16'h0300));
    pq = '{16'hfe00};
    run_row(0, 0);
    chk("row1_mem", 64'(mem[16'h0101]), 64'(16'h0000));
    // empty pass touches no memory
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_pass(16'h0400, 16'd0, 16'h0080);
    chk("zero_rows_no_mem", 64'({rd_cnt == rd0, wr_cnt == wr0}), 64'(2'b11));
    // overflow of the accumulator
    mem[16'h0300] = 16'h0000;
    start_pass(16'h0300, 16'd1, 16'h0100);
    pq = '{16'h7000, 16'h7000};
    run_row(0, 0);
`ifdef WRITEBACK_SAT_EN
    chk("overflow_value", 64'(mem[16'h0300]), 64'(16'h7fff));
`else
    chk("overflow_value", 64'(mem[16'h0300]), 64'(16'he000));
`endif
    // reset during CALC, then a fresh pass
    mem[16'h0500] = 16'h0040;
    start_pass(16'h0500, 16'd1, 16'h0100);
    pq = '{16'h0005, 16'h0006};
    run_row(0, 1);
    chk("abort_no_write", 64'(mem[16'h0500]), 64'(16'h0040));
    start_pass(16'h0500, 16'd1, 16'h0100);
    pq = '{16'h0010};
    run_row(0, 0);
    chk("after_abort_mem", 64'(mem[16'h0500]), 64'(16'h0050));
    // stray products and start while the row is in flight
    mem[16'h0600] = 16'h0100; mem[16'h0601] = 16'h0200;
    start_pass(16'h0600, 16'd2, 16'h0100);
    pq = '{16'h0001, 16'h0002};
    run_row(1, 0);
    pq = '{16'h0003};
    run_row(0, 0);
    chk("hold_row0_mem", 64'(mem[16'h0600]), 64'(16'h0103));
    chk("hold_row1_mem", 64'(mem[16'h0601]), 64'(16'h0203));
    // random passes
    for (int k = 0; k < 8; k++) begin
      logic [15:0] b, r;
      b = 16'($urandom);
      r = 16'($urandom_range(1, 3));
      for (int j = 0; j < int'(r); j++) mem[b + 16'(j)] = 16'($urandom);
      start_pass(b, r, 16'($urandom));
      for (int j = 0; j < int'(r); j++) begin
        pq = {};
        repeat ($urandom_range(1, 3)) pq.push_back(16'($urandom));
        run_row(0, 0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
